// File: rtl/ifetch.sv
// ifetch: instruction fetch unit feeding decode with 16-bit instructions and their PCs.
// Latency: a word acked at edge N has its first halfword deliverable on idone after edge N+1.
// Backpressure: decode pulls with ins_take; new reads are only issued while >=2 queue slots are free.
//
// Ports:
//   clk, reset             single clock, synchronous active-low reset
//   ins_take               decode asks for the next instruction this cycle
//   redirect, redirect_pc  control-flow change from execute (bit 0 of the PC ignored)
//   fetch_req/fetch_addr   word read request to instruction memory, held until fetch_ack
//   fetch_ack/fetch_data   read response, low halfword is the lower address
//   ins/ins_pc/idone       instruction handed to decode, idone is a one-cycle pulse
//   empty                  halfword queue is empty
module ifetch #(
  parameter int unsigned   RV        = 32,
  parameter int unsigned   QDEPTH    = 4,
  parameter logic [RV-1:0] RESET_VEC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ins_take,
  input  logic          redirect,
  input  logic [RV-1:0] redirect_pc,
  output logic          fetch_req,
  output logic [RV-3:0] fetch_addr,
  input  logic          fetch_ack,
  input  logic [31:0]   fetch_data,
  output logic [15:0]   ins,
  output logic [RV-1:0] ins_pc,
  output logic          idone,
  output logic          empty
);

  localparam int unsigned   PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned   CW = PW + 1;
  localparam logic [CW-1:0] QD = CW'(QDEPTH);

  logic [15:0]   q_mem [QDEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [RV-1:0] fpc_q, fpc_d;     // address of the next word to fetch
  logic [RV-1:0] dpc_q, dpc_d;     // PC of the queue head
  logic          req_q, req_d;
  logic [RV-3:0] addr_q, addr_d;
  logic          drop_q, drop_d;   // outstanding read belongs to a stale PC stream
  logic [15:0]   ins_q, ins_d;
  logic [RV-1:0] ins_pc_q, ins_pc_d;
  logic          idone_q, idone_d;

  logic          held;
  logic          accept;
  logic          pop;
  logic [1:0]    n_push;
  logic [RV-1:0] rpc;

  always_comb begin
    rpc    = redirect_pc & ~RV'(1);
    held   = req_q & ~fetch_ack;
    accept = req_q & fetch_ack & ~drop_q & ~redirect;
    pop    = (count_q != '0) & ins_take & ~redirect;
    // The first word after an odd redirect only carries one useful halfword.
    n_push = accept ? (fpc_q[1] ? 2'd1 : 2'd2) : 2'd0;

    fpc_d    = accept ? ((fpc_q & ~RV'(3)) + RV'(4)) : fpc_q;
    dpc_d    = pop ? dpc_q + RV'(2) : dpc_q;
    head_d   = pop ? head_q + PW'(1) : head_q;
    tail_d   = tail_q + PW'(n_push);
    count_d  = count_q + CW'(n_push) - CW'(pop);
    idone_d  = pop;
    ins_d    = pop ? q_mem[head_q] : ins_q;
    ins_pc_d = pop ? dpc_q : ins_pc_q;
    drop_d   = drop_q & ~fetch_ack;

    if (redirect) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      fpc_d   = rpc;
      dpc_d   = rpc;
      // A read still in flight would return data for the old stream; an ack in
      // this same cycle is already ignored because redirect blocks the push.
      drop_d  = held;
    end

    // Next request decided from registered-next state only, so fetch_ack has
    // no combinational route to fetch_req.
    req_d  = held | (count_d <= QD - CW'(2));
    addr_d = held ? addr_q : fpc_d[RV-1:2];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      fpc_q    <= RESET_VEC;
      dpc_q    <= RESET_VEC;
      req_q    <= 1'b0;
      addr_q   <= '0;
      drop_q   <= 1'b0;
      ins_q    <= '0;
      ins_pc_q <= '0;
      idone_q  <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      fpc_q    <= fpc_d;
      dpc_q    <= dpc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      drop_q   <= drop_d;
      ins_q    <= ins_d;
      ins_pc_q <= ins_pc_d;
      idone_q  <= idone_d;
    end
  end

  // Queue storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (fpc_q[1]) begin
        q_mem[tail_q] <= fetch_data[31:16];
      end else begin
        q_mem[tail_q]          <= fetch_data[15:0];
        q_mem[tail_q + PW'(1)] <= fetch_data[31:16];
      end
    end
  end

  assign fetch_req  = req_q;
  assign fetch_addr = addr_q;
  assign ins        = ins_q;
  assign ins_pc     = ins_pc_q;
  assign idone      = idone_q;
  assign empty      = (count_q == '0);

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed vector table, corner-case sequences and randomized traffic for ifetch.
// Latency: outputs sampled on the falling edge, inputs applied there for the next rising edge.
// Backpressure: memory responder acks with programmable latency; decode pulls randomly.
module tb_ifetch;
  localparam int          RV   = 32;
  localparam int          QD   = 4;
  localparam logic [31:0] RVEC = 32'h100;

  logic        clk = 1'b0;
  logic        reset, ins_take, redirect, fetch_ack;
  logic [31:0] redirect_pc, fetch_data;
  logic        fetch_req, idone, empty;
  logic [29:0] fetch_addr;
  logic [15:0] ins;
  logic [31:0] ins_pc;

  ifetch #(.RV(RV), .QDEPTH(QD), .RESET_VEC(RVEC)) dut (
    .clk(clk), .reset(reset), .ins_take(ins_take), .redirect(redirect),
    .redirect_pc(redirect_pc), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_data(fetch_data), .ins(ins), .ins_pc(ins_pc),
    .idone(idone), .empty(empty)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory image.
  function automatic logic [31:0] word_of(input logic [29:0] a);
    if (a == 30'h40) return 32'h2222_1111;
    if (a == 30'h81) return 32'hBBBB_AAAA;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic logic [15:0] half_at(input logic [31:1] pc);
    logic [31:0] w;
    w = word_of(pc[31:2]);
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  // Reference model: program-order view of the instruction stream.
  int          mcount;
  logic [31:0] mpc, dpc;
  logic        stale;
  logic        e_req, e_idone;
  logic [29:0] e_addr;
  logic [15:0] e_ins;
  logic [31:0] e_pc;
  bit          chk_en = 0;

  // Memory responder.
  bit          auto_on = 0, rand_lat = 0;
  int          lat = 0, rcnt = 0;
  logic        man_ack = 1'b0;
  logic [31:0] man_data = '0;

  task automatic model_edge();
    logic held, acc, pop;
    int   npush;
    if (!reset) begin
      mcount = 0; mpc = RVEC; dpc = RVEC; stale = 1'b0;
      e_req = 1'b0; e_idone = 1'b0; e_ins = '0; e_pc = '0; e_addr = '0;
    end else begin
      held  = e_req && !fetch_ack;
      acc   = e_req && fetch_ack && !redirect && !stale;
      pop   = (mcount > 0) && ins_take && !redirect;
      npush = acc ? (mpc[1] ? 1 : 2) : 0;
      if (acc) mpc = (mpc & ~32'h3) + 32'd4;
      e_idone = pop;
      if (pop) begin
        e_ins = half_at(dpc[31:1]);
        e_pc  = dpc;
        dpc   = dpc + 32'd2;
      end
      mcount = mcount + npush - int'(pop);
      if (e_req && fetch_ack) stale = 1'b0;
      if (redirect) begin
        mcount = 0;
        mpc    = redirect_pc & ~32'h1;
        dpc    = mpc;
        stale  = held;
      end
      e_req = held || (QD - mcount >= 2);
      if (!held) e_addr = mpc[31:2];
    end
  endtask

  task automatic cycle();
    if (auto_on) begin
      if (fetch_req) begin
        if (rcnt >= lat) begin
          fetch_ack  = 1'b1;
          fetch_data = word_of(fetch_addr);
          rcnt       = 0;
          if (rand_lat) lat = $urandom_range(0, 3);
        end else begin
          fetch_ack = 1'b0;
          rcnt++;
        end
      end else begin
        fetch_ack = 1'b0;
        rcnt      = 0;
      end
    end else begin
      fetch_ack  = man_ack;
      fetch_data = man_data;
    end
    if (chk_en) begin
      chk("m_idone", 32'(idone), 32'(e_idone));
      chk("m_ins", 32'(ins), 32'(e_ins));
      chk("m_ins_pc", ins_pc, e_pc);
      chk("m_empty", 32'(empty), 32'(mcount == 0));
      chk("m_fetch_req", 32'(fetch_req), 32'(e_req));
      if (e_req) chk("m_fetch_addr", 32'(fetch_addr), 32'(e_addr));
    end
    model_edge();
    @(posedge clk);
    #1 man_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic step(input logic take, input logic redir, input logic [31:0] rpc);
    ins_take    = take;
    redirect    = redir;
    redirect_pc = rpc;
    cycle();
    redirect    = 1'b0;
  endtask

  typedef struct {
    logic        rst, take, redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] data;
    logic        e_req;
    logic [29:0] e_addr;
    logic        e_idone;
    logic [15:0] e_ins;
    logic [31:0] e_pc;
    logic        e_empty;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic take, input logic redir,
                              input logic [31:0] rpc, input logic ack, input logic [31:0] data,
                              input logic rq, input logic [29:0] ad, input logic dn,
                              input logic [15:0] in, input logic [31:0] pc, input logic em);
    vec_t v;
    v.rst = rst; v.take = take; v.redir = redir; v.rpc = rpc; v.ack = ack; v.data = data;
    v.e_req = rq; v.e_addr = ad; v.e_idone = dn; v.e_ins = in; v.e_pc = pc; v.e_empty = em;
    return v;
  endfunction

  initial begin
    vec_t tv[14];
    bit   found;
    int   nid;

    tv[0]  = mk(0, 1, 0, 0,        0, 0,                 0, 0,     0, 0,       0,       1);
    tv[1]  = mk(1, 1, 0, 0,        0, 0,                 0, 0,     0, 0,       0,       1);
    tv[2]  = mk(1, 1, 0, 0,        0, 0,                 1, 'h40,  0, 0,       0,       1);
    tv[3]  = mk(1, 1, 0, 0,        1, 32'h2222_1111,     1, 'h40,  0, 0,       0,       1);
    tv[4]  = mk(1, 1, 0, 0,        0, 0,                 1, 'h41,  0, 0,       0,       0);
    tv[5]  = mk(1, 1, 0, 0,        1, word_of(30'h41),   1, 'h41,  1, 'h1111,  'h100,   0);
    tv[6]  = mk(1, 0, 0, 0,        0, 0,                 1, 'h42,  1, 'h2222,  'h102,   0);
    tv[7]  = mk(1, 0, 0, 0,        1, word_of(30'h42),   1, 'h42,  0, 'h2222,  'h102,   0);
    tv[8]  = mk(1, 0, 1, 32'h207,  0, 0,                 0, 0,     0, 'h2222,  'h102,   0);
    tv[9]  = mk(1, 1, 0, 0,        0, 0,                 1, 'h81,  0, 'h2222,  'h102,   1);
    tv[10] = mk(1, 1, 0, 0,        1, 32'hBBBB_AAAA,     1, 'h81,  0, 'h2222,  'h102,   1);
    tv[11] = mk(1, 1, 0, 0,        0, 0,                 1, 'h82,  0, 'h2222,  'h102,   0);
    tv[12] = mk(1, 1, 0, 0,        0, 0,                 1, 'h82,  1, 'hBBBB,  'h206,   1);
    tv[13] = mk(1, 0, 0, 0,        1, word_of(30'h82),   1, 'h82,  0, 'hBBBB,  'h206,   1);

    reset = 1'b0; ins_take = 1'b1; redirect = 1'b0; redirect_pc = '0;
    fetch_ack = 1'b0; fetch_data = '0;
    cycle();
    chk_en = 1;

    // Reset, first fetch and delivery, odd redirect.
    for (int i = 0; i < 14; i++) begin
      reset = tv[i].rst; man_ack = tv[i].ack; man_data = tv[i].data;
      chk("tv_idone", 32'(idone), 32'(tv[i].e_idone));
      chk("tv_ins", 32'(ins), 32'(tv[i].e_ins));
      chk("tv_ins_pc", ins_pc, tv[i].e_pc);
      chk("tv_empty", 32'(empty), 32'(tv[i].e_empty));
      chk("tv_fetch_req", 32'(fetch_req), 32'(tv[i].e_req));
      if (tv[i].e_req) chk("tv_fetch_addr", 32'(fetch_addr), 32'(tv[i].e_addr));
      step(tv[i].take, tv[i].redir, tv[i].rpc);
    end

    // Full queue: no request until two slots are free.
    auto_on = 1; lat = 0; rcnt = 0;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("full_req", 32'(fetch_req), 0);
    chk("full_empty", 32'(empty), 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("one_free_req", 32'(fetch_req), 0);
    step(1, 0, 0);
    chk("two_free_req", 32'(fetch_req), 1);

    // Redirect while a read is outstanding; its ack arrives later and is dropped.
    lat = 3;
    step(1, 1, 32'h300);
    found = 0; nid = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1, 0, 0);
      found = fetch_ack;
      if (idone) nid++;
    end
    chk("drop_ack_seen", 32'(found), 1);
    chk("drop_no_idone", nid, 0);
    chk("drop_new_req", 32'(fetch_req), 1);
    chk("drop_new_addr", 32'(fetch_addr), 32'h300 >> 2);

    // Redirect, take and ack all in the same cycle.
    lat = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (fetch_req && !empty) found = 1;
      else step(1, 0, 0);
    end
    chk("rit_setup", 32'(found), 1);
    step(1, 1, 32'h400);
    chk("rit_ack", 32'(fetch_ack), 1);
    chk("rit_idone", 32'(idone), 0);
    chk("rit_empty", 32'(empty), 1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1, 0, 0);
      found = idone;
    end
    chk("rit_deliver", 32'(found), 1);
    chk("rit_pc", ins_pc, 32'h400);
    chk("rit_ins", 32'(ins), 32'(half_at(31'h200)));

    // Reset mid-request, then a stray ack with nothing outstanding.
    auto_on = 0; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (fetch_req) found = 1;
      else step(1, 0, 0);
    end
    chk("rst_setup", 32'(found), 1);
    reset = 1'b0;
    step(0, 0, 0);
    reset = 1'b1;
    chk("rst_req", 32'(fetch_req), 0);
    chk("rst_idone", 32'(idone), 0);
    chk("rst_ins", 32'(ins), 0);
    chk("rst_ins_pc", ins_pc, 0);
    chk("rst_empty", 32'(empty), 1);
    man_ack = 1'b1; man_data = 32'hDEAD_BEEF;
    step(1, 0, 0);
    chk("stray_req", 32'(fetch_req), 1);
    chk("stray_addr", 32'(fetch_addr), 32'h40);
    chk("stray_empty", 32'(empty), 1);
    man_ack = 1'b1; man_data = word_of(30'h40);
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      step(1, 0, 0);
      found = idone;
    end
    chk("restart_deliver", 32'(found), 1);
    chk("restart_ins", 32'(ins), 32'h1111);
    chk("restart_pc", ins_pc, 32'h100);

    // Randomized traffic against the model.
    auto_on = 1; rand_lat = 1; rcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      int tp;
      tp    = ((i / 200) % 2 == 0) ? 8 : 3;
      reset = ($urandom_range(0, 299) != 0);
      step($urandom_range(0, 9) < tp, $urandom_range(0, 99) < 4, $urandom & 32'hFFFF);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
